// File: rtl/rr_hold_arbiter.sv
// rr_hold_arbiter
//   Four-requester round-robin arbiter for one shared resource. A grant is
//   held until the owner strobes done, drops its request, or has held the
//   resource for MAX_HOLD cycles (forced release, flagged by timeout).
//   A release always returns to IDLE for one cycle. New arbitration happens
//   only in that IDLE cycle.
//
// Ports
//   clock     in   rising-edge clock
//   reset     in   synchronous, active-high reset
//   req       in   [3:0] level request per requester
//   done      in   [3:0] release strobe; only the current owner's bit counts
//   en        in   arbitration enable; gates new grants only
//   gnt       out  [3:0] registered one-hot grant, zero when idle
//   gnt_id    out  [1:0] index of current owner, zero when idle
//   busy      out  grant active (OR of gnt)
//   hold_cnt  out  [CW-1:0] cycles elapsed in the current grant
//   timeout   out  one-cycle pulse when a forced release is registered
module rr_hold_arbiter #(
    parameter int MAX_HOLD = 8,
    parameter int CW       = 8
) (
    input  logic          clock,
    input  logic          reset,
    input  logic [3:0]    req,
    input  logic [3:0]    done,
    input  logic          en,
    output logic [3:0]    gnt,
    output logic [1:0]    gnt_id,
    output logic          busy,
    output logic [CW-1:0] hold_cnt,
    output logic          timeout
);

    typedef enum logic {IDLE, GRANT} state_t;

    state_t        state_q;
    logic [1:0]    ptr_q;
    logic [3:0]    gnt_q;
    logic [1:0]    gnt_id_q;
    logic          busy_q;
    logic [CW-1:0] hold_cnt_q;
    logic          timeout_q;

    // Winner search: first requester at or after ptr_q, wrapping mod 4.
    // Scanning from the farthest offset down lets the nearest one win.
    logic       win_vld_d;
    logic [1:0] win_id_d;
    logic [1:0] idx;

    always_comb begin
        win_vld_d = 1'b0;
        win_id_d  = '0;
        idx       = '0;
        for (int i = 3; i >= 0; i--) begin
            idx = ptr_q + 2'(i);
            if (req[idx]) begin
                win_vld_d = 1'b1;
                win_id_d  = idx;
            end
        end
    end

    // Release conditions for the current owner. A done or dropped request
    // takes precedence over the hold limit, so timeout stays low then.
    logic normal_rel_d;
    logic limit_hit_d;

    assign normal_rel_d = done[gnt_id_q] | ~req[gnt_id_q];
    assign limit_hit_d  = (hold_cnt_q == CW'(MAX_HOLD - 1));

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= IDLE;
            ptr_q      <= '0;
            gnt_q      <= '0;
            gnt_id_q   <= '0;
            busy_q     <= 1'b0;
            hold_cnt_q <= '0;
            timeout_q  <= 1'b0;
        end else begin
            timeout_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (en && win_vld_d) begin
                        state_q    <= GRANT;
                        gnt_q      <= 4'(1) << win_id_d;
                        gnt_id_q   <= win_id_d;
                        busy_q     <= 1'b1;
                        hold_cnt_q <= '0;
                        ptr_q      <= win_id_d + 2'd1;
                    end
                end
                GRANT: begin
                    if (normal_rel_d || limit_hit_d) begin
                        state_q    <= IDLE;
                        gnt_q      <= '0;
                        gnt_id_q   <= '0;
                        busy_q     <= 1'b0;
                        hold_cnt_q <= '0;
                        timeout_q  <= ~normal_rel_d;
                    end else begin
                        hold_cnt_q <= hold_cnt_q + CW'(1);
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign gnt      = gnt_q;
    assign gnt_id   = gnt_id_q;
    assign busy     = busy_q;
    assign hold_cnt = hold_cnt_q;
    assign timeout  = timeout_q;

endmodule

// File: tb/tb_rr_hold_arbiter.sv
module tb_rr_hold_arbiter;

    logic       clock = 1'b0;
    logic       reset;
    logic [3:0] req;
    logic [3:0] done;
    logic       en;
    logic [3:0] gnt;
    logic [1:0] gnt_id;
    logic       busy;
    logic [7:0] hold_cnt;
    logic       timeout;

    int n_chk = 0;
    int n_err = 0;

    rr_hold_arbiter #(.MAX_HOLD(8), .CW(8)) dut (
        .clock(clock), .reset(reset), .req(req), .done(done), .en(en),
        .gnt(gnt), .gnt_id(gnt_id), .busy(busy), .hold_cnt(hold_cnt),
        .timeout(timeout)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one edge and settle past it.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Full output check against an expected owner (or idle when act=0).
    task automatic chk_out(input string tag, input logic act, input int id,
                           input int hc, input logic to);
        chk({tag, ".gnt"},     32'(gnt),      act ? (32'd1 << id) : 32'd0);
        chk({tag, ".gnt_id"},  32'(gnt_id),   act ? 32'(id) : 32'd0);
        chk({tag, ".busy"},    32'(busy),     32'(act));
        chk({tag, ".hold"},    32'(hold_cnt), 32'(hc));
        chk({tag, ".timeout"}, 32'(timeout),  32'(to));
    endtask

    initial begin
        int ord[5];
        ord = '{0, 1, 2, 3, 0};
        reset = 1'b1; req = '0; done = '0; en = 1'b0;
        tick(); tick();
        chk_out("reset", 1'b0, 0, 0, 1'b0);

        // Round robin, each owner releases on its 2nd grant cycle.
        reset = 1'b0; req = 4'b1111; en = 1'b1;
        for (int k = 0; k < 5; k++) begin
            tick();
            chk_out($sformatf("rr%0d.c0", k), 1'b1, ord[k], 0, 1'b0);
            tick();
            chk_out($sformatf("rr%0d.c1", k), 1'b1, ord[k], 1, 1'b0);
            done = 4'(1 << ord[k]);
            tick();
            chk_out($sformatf("rr%0d.idle", k), 1'b0, 0, 0, 1'b0);
            done = '0;
        end

        // Forced release after MAX_HOLD cycles (ptr is 1 here).
        req = 4'b0100;
        tick();
        for (int h = 0; h < 8; h++) begin
            chk_out($sformatf("hold%0d", h), 1'b1, 2, h, 1'b0);
            if (h < 7) tick();
        end
        tick();
        chk_out("forced", 1'b0, 0, 0, 1'b1);
        tick();
        chk_out("regrant2", 1'b1, 2, 0, 1'b0);

        // Owner 2 abandons mid-tenure.
        tick(); tick(); tick();
        chk_out("own2.h3", 1'b1, 2, 3, 1'b0);
        req = 4'b0000;
        tick();
        chk_out("abandon", 1'b0, 0, 0, 1'b0);
        done = 4'b1111;  // done with no grant must be ignored
        tick();
        chk_out("idle_done", 1'b0, 0, 0, 1'b0);
        done = '0;

        // Owner 1: non-owner done ignored; own done at limit -> no timeout.
        req = 4'b0010;
        tick();
        chk_out("own1.c0", 1'b1, 1, 0, 1'b0);
        done = 4'b0101;
        for (int h = 1; h <= 6; h++) tick();
        chk_out("own1.h6", 1'b1, 1, 6, 1'b0);
        tick();
        chk_out("own1.h7", 1'b1, 1, 7, 1'b0);
        done = 4'b0010;
        tick();
        chk_out("done_at_lim", 1'b0, 0, 0, 1'b0);
        done = '0;

        // Owner 3 with en dropped; no new grant until en returns, ptr wraps to 0.
        req = 4'b1000;
        tick();
        chk_out("own3.c0", 1'b1, 3, 0, 1'b0);
        req = 4'b1111; en = 1'b0;
        tick();
        chk_out("own3.en0", 1'b1, 3, 1, 1'b0);
        done = 4'b1000;
        tick();
        chk_out("own3.rel", 1'b0, 0, 0, 1'b0);
        done = '0;
        tick(); tick();
        chk_out("en0.idle", 1'b0, 0, 0, 1'b0);
        en = 1'b1;
        tick();
        chk_out("wrap0", 1'b1, 0, 0, 1'b0);

        // Reset mid-grant of owner 3 at hold 5.
        done = 4'b0001;
        tick();
        done = '0; req = 4'b1000;
        tick();
        chk_out("own3b.c0", 1'b1, 3, 0, 1'b0);
        for (int h = 0; h < 5; h++) tick();
        chk_out("own3b.h5", 1'b1, 3, 5, 1'b0);
        reset = 1'b1;
        tick();
        chk_out("mid_reset", 1'b0, 0, 0, 1'b0);
        reset = 1'b0; req = 4'b1010;
        tick();
        chk_out("post_reset", 1'b1, 1, 0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

    // Global watchdog.
    initial begin
        #20000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

endmodule

// File: doc/rr_hold_arbiter.md
Name: rr_hold_arbiter

Overview:
- Four-requester round-robin arbiter that shares one resource (bus/port) and holds each grant until the owner releases it.
- Rotating priority pointer advances past each winner; a hold-cycle limit forces release from an owner that never finishes.
- Sits between requesting units and the shared resource; gnt drives the resource mux select and enable.

Parameters:
- MAX_HOLD, 8, maximum cycles one grant may be held before forced release (legal 2..255).
- CW, 8, width of hold_cnt (must hold MAX_HOLD-1).

Ports:
- clock  input  1  rising-edge clock.
- reset  input  1  reset, synchronous, active-high.
- req  input  4  request per requester; level, held until served.
- done  input  4  release strobe per requester; only the owner's bit is honoured.
- en  input  1  arbitration enable; gates new grants only.
- gnt  output  4  registered one-hot grant, all zero when idle.
- gnt_id  output  2  index of current owner, 0 when idle.
- busy  output  1  high while a grant is active (equals OR of gnt).
- hold_cnt  output  CW  cycles elapsed in current grant, 0 in IDLE.
- timeout  output  1  one-cycle pulse on the cycle a forced release is registered.

Behaviour:
- State is IDLE or GRANT. All outputs are registered.
- Reset (synchronous, any state): state=IDLE, gnt=0, gnt_id=0, busy=0, hold_cnt=0, timeout=0, ptr=0.
- Priority pointer ptr (2 bits): search order ptr, ptr+1, ptr+2, ptr+3, all mod 4. First requester in that order with req high wins.
- IDLE:
  - If en=1 and req!=0 at edge n, then from n+1: state=GRANT, gnt=onehot(w), gnt_id=w, busy=1, hold_cnt=0, ptr=(w+1) mod 4.
  - Otherwise remain IDLE with outputs at zero.
- GRANT: owner o is fixed for the whole tenure. Other requesters' req/done changes are ignored.
- Each GRANT cycle, evaluate release in this order:
  - done[o]=1 → normal release.
  - req[o]=0 → normal release (owner abandoned).
  - hold_cnt==MAX_HOLD-1 → forced release, timeout=1 for the next cycle.
  - Otherwise stay in GRANT and increment hold_cnt.
- On release at edge n, from n+1: state=IDLE, gnt=0, gnt_id=0, busy=0, hold_cnt=0. There is one mandatory dead cycle between grants; re-arbitration happens in that IDLE cycle.
- Tenure limits:
  - Maximum tenure is MAX_HOLD cycles with gnt high.
  - Minimum tenure is 1 cycle: done is allowed on the first grant cycle.
- done[o] and the timeout condition in the same cycle: treat as normal release, timeout=0.
- en=0 during GRANT: current tenure continues to normal or forced release; no new grant until en=1.
- done with no active grant, or done from a non-owner: ignored, no state change.
- req fully low in IDLE: no grant, ptr unchanged.
- Fairness: with all four requesting continuously and each holding k cycles, grant order is 0,1,2,3,0,... Each requester waits at most 3*(MAX_HOLD+1) cycles from req high to gnt high.
- Reset asserted mid-grant: gnt drops at the next edge; the first grant after reset starts search at requester 0.
- gnt is never multi-hot. gnt_id, busy and gnt are mutually consistent every cycle.

Test Plan:
- Reset then req=4'b1111, en=1, each owner pulses done on its 2nd grant cycle → grant sequence gnt=0001,0010,0100,1000,0001, each grant 2 cycles high followed by 1 idle cycle; timeout never asserts.
- req=4'b0100 held, done never asserted, MAX_HOLD=8 → gnt=0100 for exactly 8 cycles (hold_cnt 0..7); timeout=1 on the cycle gnt drops; next grant to requester 2 after 1 idle cycle.
- Owner 1 active, done=4'b0101 (non-owner bits set) → no release. Then done=4'b0010 on the same cycle hold_cnt=7 → release with timeout=0.
- en=0 while owner 3 holds, req=4'b1111 → owner 3 keeps gnt until done[3]. Gnt then stays 0 until en=1. Next grant goes to requester 0 (ptr=0 after wrap from 3).
- Owner 2 drops req[2] mid-tenure without done → gnt=0 next cycle, hold_cnt=0, timeout=0.
- reset asserted while gnt=1000 and hold_cnt=5 → next cycle all outputs 0. With req=4'b1010 after reset, first grant is 0010.
